// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: data memory, branch resolve, MEM/WB register
module mem_stage #(
  parameter int MEM_WORDS = 256,
  parameter int LAT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] branch_target,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  dest_reg,
  output logic        pcsrc,
  output logic [31:0] pc_branch,
  output logic        stall,
  output logic        misalign,
  output logic [1:0]  wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  dest_reg_out
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LAT + 1);
  localparam int unsigned CNT_INIT = (LAT > 1) ? LAT - 2 : 0;
  localparam bit SINGLE = (LAT == 1);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    wb_q, wb_d;
  logic [31:0]   rd_q, rd_d;
  logic [31:0]   alu_q, alu_d;
  logic [4:0]    dest_q, dest_d;

  logic [31:0]   mem_q [MEM_WORDS];

  logic [AW-1:0] idx;
  logic          access;
  logic          aligned;
  logic          complete;
  logic          stall_c;
  logic          misalign_c;
  logic          mem_we;

  assign idx     = alu_result[AW+1:2];
  assign access  = memread | memwrite;
  assign aligned = (alu_result[1:0] == 2'b00);

  assign pcsrc     = branch & zero;
  assign pc_branch = branch_target;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    complete   = 1'b0;
    wb_d       = wb_in;
    alu_d      = alu_result;
    dest_d     = dest_reg;
    rd_d       = 32'd0;
    case (state_q)
      IDLE: begin
        if (access && !aligned) begin
          misalign_c = 1'b1;
          wb_d       = 2'b00;
        end else if (access) begin
          if (SINGLE) begin
            complete = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = BUSY;
            cnt_d   = CW'(CNT_INIT);
            wb_d    = 2'b00;
            alu_d   = 32'd0;
            dest_d  = 5'd0;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CW'(1);
          wb_d    = 2'b00;
          alu_d   = 32'd0;
          dest_d  = 5'd0;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Simultaneous read+write is a store, so the load path only fires without memwrite.
    if (complete && memread && !memwrite) rd_d = mem_q[idx];
  end

  // Reset gates both handshake outputs and the write strobe so an aborted store never lands.
  assign stall    = stall_c & rst;
  assign misalign = misalign_c & rst;
  assign mem_we   = complete & memwrite & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= 2'b00;
      rd_q    <= 32'd0;
      alu_q   <= 32'd0;
      dest_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      dest_q  <= dest_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= write_data;
  end

  assign wb_out         = wb_q;
  assign read_data_out  = rd_q;
  assign alu_result_out = alu_q;
  assign dest_reg_out   = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage (LAT=2)
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  wb_in;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic [31:0] branch_target;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  dest_reg;
  logic        pcsrc;
  logic [31:0] pc_branch;
  logic        stall;
  logic        misalign;
  logic [1:0]  wb_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  dest_reg_out;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.MEM_WORDS(256), .LAT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_in          (wb_in),
    .branch         (branch),
    .memread        (memread),
    .memwrite       (memwrite),
    .branch_target  (branch_target),
    .zero           (zero),
    .alu_result     (alu_result),
    .write_data     (write_data),
    .dest_reg       (dest_reg),
    .pcsrc          (pcsrc),
    .pc_branch      (pc_branch),
    .stall          (stall),
    .misalign       (misalign),
    .wb_out         (wb_out),
    .read_data_out  (read_data_out),
    .alu_result_out (alu_result_out),
    .dest_reg_out   (dest_reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_in      = 2'b00;
    branch     = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    zero       = 1'b0;
    alu_result = 32'd0;
    write_data = 32'd0;
    dest_reg   = 5'd0;
  endtask

  // Full LAT=2 access: one stall cycle, one bubble edge, then completion.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] wb, input logic [4:0] dst,
                           input logic [31:0] exp_rd);
    memread    = rd;
    memwrite   = wr;
    alu_result = addr;
    write_data = wdata;
    wb_in      = wb;
    dest_reg   = dst;
    #1;
    check({tag, "_stall0"}, {31'd0, stall}, 32'd1);
    step();
    check({tag, "_bubble_wb"}, {30'd0, wb_out}, 32'd0);
    check({tag, "_bubble_alu"}, alu_result_out, 32'd0);
    check({tag, "_stall1"}, {31'd0, stall}, 32'd0);
    step();
    check({tag, "_wb"}, {30'd0, wb_out}, {30'd0, wb});
    check({tag, "_alu"}, alu_result_out, addr);
    check({tag, "_dest"}, {27'd0, dest_reg_out}, {27'd0, dst});
    check({tag, "_rdata"}, read_data_out, exp_rd);
    idle_inputs();
  endtask

  initial begin
    branch_target = 32'd0;
    idle_inputs();
    rst        = 1'b0;
    memwrite   = 1'b1;
    alu_result = 32'h20;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    step();
    step();
    check("rst_wb", {30'd0, wb_out}, 32'd0);
    check("rst_rdata", read_data_out, 32'd0);
    check("rst_dest", {27'd0, dest_reg_out}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    idle_inputs();
    rst = 1'b1;
    step();

    // Pass-through with no access
    wb_in      = 2'b10;
    alu_result = 32'd30;
    dest_reg   = 5'd10;
    #1;
    check("pt_stall", {31'd0, stall}, 32'd0);
    step();
    check("pt_wb", {30'd0, wb_out}, 32'd2);
    check("pt_alu", alu_result_out, 32'd30);
    check("pt_dest", {27'd0, dest_reg_out}, 32'd10);
    check("pt_rdata", read_data_out, 32'd0);
    check("pt_stall2", {31'd0, stall}, 32'd0);
    idle_inputs();

    // Back-to-back store then load at the same address
    do_access("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0, 32'd0);
    do_access("ld10", 1'b1, 1'b0, 32'h10, 32'd0, 2'b11, 5'd5, 32'hDEADBEEF);

    // Branch resolution is combinational
    branch        = 1'b1;
    zero          = 1'b1;
    branch_target = 32'd100;
    #1;
    check("br_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("br_target", pc_branch, 32'd100);
    zero = 1'b0;
    #1;
    check("br_nz_pcsrc", {31'd0, pcsrc}, 32'd0);
    idle_inputs();

    // Misaligned store (0x13 maps to the same word as 0x10)
    memwrite   = 1'b1;
    alu_result = 32'h13;
    write_data = 32'h12345678;
    wb_in      = 2'b10;
    dest_reg   = 5'd7;
    #1;
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_stall", {31'd0, stall}, 32'd0);
    step();
    check("mis_wb", {30'd0, wb_out}, 32'd0);
    check("mis_alu", alu_result_out, 32'h13);
    check("mis_dest", {27'd0, dest_reg_out}, 32'd7);
    idle_inputs();
    #1;
    check("mis_drop", {31'd0, misalign}, 32'd0);
    do_access("ld_after_mis", 1'b1, 1'b0, 32'h10, 32'd0, 2'b11, 5'd3, 32'hDEADBEEF);

    // Read+write together behaves as a store
    do_access("rw30", 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 2'b00, 5'd0, 32'd0);
    do_access("ld30", 1'b1, 1'b0, 32'h30, 32'd0, 2'b11, 5'd4, 32'hCAFEF00D);

    // Address wraps modulo MEM_WORDS: 0x410 aliases word 4
    do_access("ld_wrap", 1'b1, 1'b0, 32'h410, 32'd0, 2'b11, 5'd6, 32'hDEADBEEF);

    // Reset aborts a pending store
    do_access("st20a", 1'b0, 1'b1, 32'h20, 32'h000000AA, 2'b00, 5'd0, 32'd0);
    memwrite   = 1'b1;
    alu_result = 32'h20;
    write_data = 32'h55;
    #1;
    check("abort_stall_pre", {31'd0, stall}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_stall_drop", {31'd0, stall}, 32'd0);
    step();
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    check("abort_wb", {30'd0, wb_out}, 32'd0);
    do_access("ld20_abort", 1'b1, 1'b0, 32'h20, 32'd0, 2'b11, 5'd8, 32'h000000AA);
    do_access("st20b", 1'b0, 1'b1, 32'h20, 32'h11, 2'b00, 5'd0, 32'd0);
    do_access("ld20b", 1'b1, 1'b0, 32'h20, 32'd0, 2'b11, 5'd9, 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline memory-access stage that consumes the EX/MEM bundle produced by the execute stage: wb, branch, memread, memwrite, add result, zero, ALU result, forwarded read-data-2 and the 5-bit destination register.
- Contains the word-addressed data memory, resolves branches (pcsrc), and owns the MEM/WB pipeline register.
- Supports a multi-cycle data memory through a stall handshake back to the hazard/PC logic.

Parameters:
MEM_WORDS, 256, data memory depth in 32-bit words (power of 2); AW = clog2(MEM_WORDS)
LAT, 2, data-memory access latency in cycles (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-low reset
wb_in  in  2  writeback control from EX/MEM ([1]=RegWrite, [0]=MemtoReg)
branch  in  1  branch instruction flag
memread  in  1  load request
memwrite  in  1  store request
branch_target  in  32  branch adder result
zero  in  1  ALU zero flag
alu_result  in  32  ALU result; byte address for loads and stores
write_data  in  32  store data (readdat2 path)
dest_reg  in  5  destination register (mux5 output)
pcsrc  out  1  branch taken = branch & zero (combinational)
pc_branch  out  32  branch_target passthrough (combinational)
stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM while high
misalign  out  1  one-cycle pulse on a misaligned access
wb_out  out  2  MEM/WB writeback control
read_data_out  out  32  MEM/WB load data
alu_result_out  out  32  MEM/WB ALU result
dest_reg_out  out  5  MEM/WB destination register

Behaviour:
- Reset (rst=0, async): MEM/WB outputs all zero, FSM=IDLE, cnt=0, misalign=0, stall forced 0. Memory array is not cleared; contents are undefined until written.
- Address: word index = alu_result[AW+1:2]. Upper bits are ignored and wrap modulo MEM_WORDS.
- access = memread | memwrite. aligned = (alu_result[1:0] == 0).
- Misaligned access:
  - No memory read or write.
  - misalign=1 for that cycle; no stall.
  - MEM/WB loads a bubble: wb_out=00, read_data_out=0, alu_result_out=alu_result, dest_reg_out=dest_reg.
- memread and memwrite both high: treated as a store; read_data_out=0.
- FSM states: IDLE, BUSY. Counter cnt has clog2(LAT+1) bits.
  - IDLE, aligned access, LAT>1: stall=1 (combinational, same cycle); next state BUSY with cnt=LAT-2; MEM/WB loads a bubble (wb_out=00, other fields zero).
  - BUSY with cnt!=0: stall=1, cnt decrements, MEM/WB loads a bubble.
  - BUSY with cnt==0: stall=0, access completes at this edge, next state IDLE.
  - LAT=1: completes in the presentation cycle; BUSY is never entered; stall never asserts.
- Completion edge:
  - Store: mem[idx] <= write_data, committed exactly once.
  - Load: read_data_out <= mem[idx], the pre-edge contents.
  - MEM/WB loads wb_in, alu_result, dest_reg.
- Non-access cycle: MEM/WB loads wb_in, alu_result, dest_reg; read_data_out=0; stall=0.
- Total latency: a presented access reaches MEM/WB LAT edges after presentation, and stall is high for LAT-1 cycles.
- Upstream holds EX/MEM stable while stall=1. Input changes during BUSY are ignored except on the completion cycle.
- Back-to-back store then load to the same address: the load returns the new data, because the store committed at an earlier edge.
- pcsrc and pc_branch are purely combinational and independent of stall (branches never access memory).
- Reset asserted mid-access: abort, pending store not committed, FSM=IDLE, stall drops immediately.

Test Plan:
- Reset: rst=0 with memwrite=1 -> stall=0, wb_out=00, read_data_out=0, dest_reg_out=0; release -> FSM IDLE.
- Store/load, LAT=2: memwrite, alu_result=0x10, write_data=0xDEADBEEF -> stall high 1 cycle, MEM/WB bubble then wb_in. Next, memread at 0x10 -> read_data_out=0xDEADBEEF 2 edges later, stall high 1 cycle.
- Branch: branch=1, zero=1, branch_target=100 -> pcsrc=1, pc_branch=100 same cycle. zero=0 -> pcsrc=0.
- Pass-through: wb_in=10, alu_result=30, dest_reg=10, no access -> next edge wb_out=10, alu_result_out=30, dest_reg_out=10, read_data_out=0, stall never high.
- Misaligned: memwrite at alu_result=0x13 -> misalign pulses 1 cycle, stall=0, wb_out=00. A later load at 0x10 returns the prior contents unchanged.
- Reset mid-access: memwrite 0x20 = 0x55, rst=0 during the stall cycle -> stall drops at once. Store 0x20 = 0x11 then load 0x20 -> 0x11; separately, load 0x20 before any rewrite -> not 0x55.
